// File: rtl/imem_loader.sv
// imem_loader
//   Program loader sitting directly in front of the instruction memory.
//   Words arriving on a valid/ready stream are written to consecutive
//   addresses starting at 0. run_en is raised only after a load has
//   finished cleanly, so the core never fetches from a half-written memory.
//
// Configuration macro: IMEM_NOP_PAD_EN
//   Defined   : after the last word, the rest of the memory (wptr..DEPTH-1)
//               is padded with NOP 9'b100000000, one write per cycle, before
//               load_done rises.
//   Undefined : the last word goes straight to DONE; unwritten addresses
//               keep their previous contents.
//
// Ports
//   clk          in   clock
//   reset_n      in   synchronous active-low reset
//   load_start   in   one-cycle pulse, starts a load from IDLE or DONE
//   in_valid     in   source presents in_data
//   in_data      in   [INSTR_W-1:0] instruction word
//   in_last      in   final word marker, looked at only on a handshake
//   in_ready     out  loader accepts a word this cycle (high only in LOAD)
//   imem_we      out  instruction-memory write strobe (registered)
//   imem_addr    out  [ADDR_W-1:0] write address
//   imem_wdata   out  [INSTR_W-1:0] write data
//   load_count   out  [ADDR_W:0] words accepted in current/last load
//   load_done    out  load finished (held level)
//   load_err     out  DEPTH words accepted without in_last (sticky)
//   run_en       out  load_done & ~load_err
//   state_dbg    out  [1:0] current FSM state, for observation only
//
// Handshake: a word transfers on a rising edge where in_valid & in_ready
// are both high; in_ready is a combinational function of state only and
// never depends on in_valid.
module imem_loader #(
   parameter int INSTR_W = 9,
   parameter int ADDR_W  = 10,
   parameter int DEPTH   = 1024
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load_start,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_data,
   input  logic               in_last,
   output logic               in_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic [ADDR_W:0]    load_count,
   output logic               load_done,
   output logic               load_err,
   output logic               run_en,
   output logic [1:0]         state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } state_t;

   // wptr is one bit wider than the address so that it can hold DEPTH
   // after the last slot is written without wrapping back to 0.
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
`ifdef IMEM_NOP_PAD_EN
   localparam logic [INSTR_W-1:0] NOP = INSTR_W'(9'b100000000);
`endif

   state_t          state, state_next;
   logic [ADDR_W:0] wptr;
   logic            hs;       // word accepted this cycle
   logic            fill_wr;  // NOP pad write this cycle
   logic            clear;    // new load begins
   logic            err_set;  // overflow detected

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      hs         = 1'b0;
      fill_wr    = 1'b0;
      clear      = 1'b0;
      err_set    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (load_start) begin
               state_next = LOAD;
               clear      = 1'b1;
            end
         end
         LOAD: begin
            hs = in_valid;
            if (hs) begin
               if (in_last) begin
`ifdef IMEM_NOP_PAD_EN
                  state_next = FILL;
`else
                  state_next = DONE;
`endif
               end else if (wptr == LAST_IDX) begin
                  state_next = DONE;
                  err_set    = 1'b1;
               end
            end
         end
         FILL: begin
`ifdef IMEM_NOP_PAD_EN
            // A full load leaves wptr at DEPTH: nothing to pad, exit at once.
            fill_wr = (wptr < DEPTH_C);
            if (wptr >= LAST_IDX) state_next = DONE;
`else
            state_next = DONE;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wptr       <= '0;
         load_count <= '0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         if (clear) begin
            wptr       <= '0;
            load_count <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
         end else begin
            if (hs) begin
               imem_we    <= 1'b1;
               imem_addr  <= wptr[ADDR_W-1:0];
               imem_wdata <= in_data;
               wptr       <= wptr + 1'b1;
               if (load_count < DEPTH_C) load_count <= load_count + 1'b1;
            end
`ifdef IMEM_NOP_PAD_EN
            if (fill_wr) begin
               imem_we    <= 1'b1;
               imem_addr  <= wptr[ADDR_W-1:0];
               imem_wdata <= NOP;
               wptr       <= wptr + 1'b1;
            end
`endif
            if (err_set) load_err <= 1'b1;
            // Registered from state so it rises one cycle after the final write.
            if (state == DONE) load_done <= 1'b1;
         end
      end
   end

   assign in_ready  = (state == LOAD);
   assign run_en    = load_done & ~load_err;
   assign state_dbg = state;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int INSTR_W = 9;
  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 1024;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic               load_start = 1'b0;
  logic               in_valid   = 1'b0;
  logic [INSTR_W-1:0] in_data    = '0;
  logic               in_last    = 1'b0;
  logic               in_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic [ADDR_W:0]    load_count;
  logic               load_done;
  logic               load_err;
  logic               run_en;
  logic [1:0]         state_dbg;

  imem_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .load_count(load_count), .load_done(load_done),
    .load_err(load_err), .run_en(run_en), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [ADDR_W+INSTR_W-1:0] exp_q[$];
  logic [ADDR_W+INSTR_W-1:0] mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of exp_q
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(imem_we), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr_data", 32'({imem_addr, imem_wdata}), 32'(mon_e));
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
  endtask

  task automatic send(input int addr, input logic [INSTR_W-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    exp_q.push_back({ADDR_W'(addr), d});
    @(negedge clk);
    check("in_ready_on_send", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (load_done !== 1'b1 && k < 3000) begin
      tick(1);
      k++;
    end
    check("load_done_timeout", 32'(load_done), 32'd1);
  endtask

`ifdef IMEM_NOP_PAD_EN
  task automatic push_pad(input int from);
    for (int a = from; a < DEPTH; a++) exp_q.push_back({ADDR_W'(a), 9'h100});
  endtask
`endif

  initial begin
    // reset for 2 cycles, release, no stimulus
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_run_en", 32'(run_en), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // in_valid in IDLE is ignored
    in_valid = 1'b1;
    in_data  = 9'h1AA;
    tick(2);
    in_valid = 1'b0;
    check("idle_valid_count", 32'(load_count), 32'd0);

    // 3-word load
    pulse_start();
    send(0, 9'h0A1, 1'b0);
    send(1, 9'h0B2, 1'b0);
    send(2, 9'h1C3, 1'b1);
`ifdef IMEM_NOP_PAD_EN
    push_pad(3);
`endif
    check("last_write_cycle_we", 32'(imem_we), 32'd1);
    check("last_write_cycle_done", 32'(load_done), 32'd0);
    check("last_write_cycle_ready", 32'(in_ready), 32'd0);
    wait_done();
    check("l3_count", 32'(load_count), 32'd3);
    check("l3_run_en", 32'(run_en), 32'd1);
    check("l3_err", 32'(load_err), 32'd0);
    check("l3_drained", 32'(exp_q.size()), 32'd0);

    // restart from DONE; gaps in in_valid 1,0,0,1,1
    pulse_start();
    check("restart_run_en", 32'(run_en), 32'd0);
    check("restart_count", 32'(load_count), 32'd0);
    send(0, 9'h011, 1'b0);
    in_data = 9'h1FF;
    tick(2);
    send(1, 9'h122, 1'b0);
    send(2, 9'h033, 1'b1);
`ifdef IMEM_NOP_PAD_EN
    push_pad(3);
`endif
    wait_done();
    check("gap_count", 32'(load_count), 32'd3);
    check("gap_run_en", 32'(run_en), 32'd1);
    check("gap_drained", 32'(exp_q.size()), 32'd0);

    // overflow: DEPTH words without in_last
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send(i, INSTR_W'(i * 7 + 3), 1'b0);
    check("ovf_err", 32'(load_err), 32'd1);
    check("ovf_run_en", 32'(run_en), 32'd0);
    check("ovf_count", 32'(load_count), 32'd1024);
    check("ovf_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 9'h155;
    tick(3);
    in_valid = 1'b0;
    check("ovf_count_after", 32'(load_count), 32'd1024);
    check("ovf_done", 32'(load_done), 32'd1);
    check("ovf_run_en_after", 32'(run_en), 32'd0);
    check("ovf_drained", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a load, then a 2-word load
    pulse_start();
    for (int i = 0; i < 5; i++) send(i, INSTR_W'(9'h040 + i), 1'b0);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("mid_rst_count", 32'(load_count), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    pulse_start();
    send(0, 9'h0DE, 1'b0);
    send(1, 9'h1AD, 1'b1);
`ifdef IMEM_NOP_PAD_EN
    push_pad(2);
`endif
    wait_done();
    check("post_rst_count", 32'(load_count), 32'd2);
    check("post_rst_run_en", 32'(run_en), 32'd1);
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
